// File: rtl/flp_accumulator.sv
// rtl/flp_accumulator.sv - iterative pseudo-floating-point accumulator (accept, align, add/normalize)
module flp_accumulator #(
    parameter int EXP_WIDTH   = 9,
    parameter int MANT_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_WIDTH-1:0]   in_exp,
    input  logic [MANT_WIDTH-1:0]  in_mant,
    input  logic                   in_last,
    output logic                   out_valid,
    output logic [EXP_WIDTH-1:0]   out_exp,
    output logic [MANT_WIDTH-1:0]  out_mant,
    output logic                   out_ovf,
    output logic [COUNT_WIDTH-1:0] out_count
);

    typedef enum logic [1:0] {S_WAIT, S_ALIGN, S_ADD, S_DONE} state_t;

    state_t state, state_next;

    logic [EXP_WIDTH-1:0]   acc_exp, op_exp, big_exp;
    logic [MANT_WIDTH-1:0]  acc_mant, op_mant, big_mant, small_shifted;
    logic                   ovf_sticky, op_last;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   accept;

    logic                   op_bigger;
    logic [EXP_WIDTH-1:0]   exp_diff;
    logic [EXP_WIDTH-1:0]   al_big_exp;
    logic [MANT_WIDTH-1:0]  al_big_mant, al_small_src, al_small;

    logic [MANT_WIDTH:0]    sum;
    logic [EXP_WIDTH-1:0]   add_exp;
    logic [MANT_WIDTH-1:0]  add_mant;
    logic                   add_ovf;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_WAIT: begin
                in_ready = ~rst;
                if (in_valid)
                    state_next = S_ALIGN;
            end
            S_ALIGN: state_next = S_ADD;
            S_ADD:   state_next = op_last ? S_DONE : S_WAIT;
            S_DONE:  state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    assign accept = in_valid && in_ready;

    // A zero accumulator or zero operand never contributes an aligned small term.
    always_comb begin
        op_bigger    = op_exp > acc_exp;
        exp_diff     = op_bigger ? (op_exp - acc_exp) : (acc_exp - op_exp);
        al_big_exp   = acc_exp;
        al_big_mant  = acc_mant;
        al_small_src = op_mant;
        if (acc_mant == '0) begin
            al_big_exp   = op_exp;
            al_big_mant  = op_mant;
            al_small_src = '0;
        end else if (op_mant == '0) begin
            al_small_src = '0;
        end else if (op_bigger) begin
            al_big_exp   = op_exp;
            al_big_mant  = op_mant;
            al_small_src = acc_mant;
        end
        al_small = (exp_diff >= EXP_WIDTH'(MANT_WIDTH)) ? '0 : (al_small_src >> exp_diff);
    end

    always_comb begin
        sum      = {1'b0, big_mant} + {1'b0, small_shifted};
        add_exp  = big_exp;
        add_mant = sum[MANT_WIDTH-1:0];
        add_ovf  = ovf_sticky;
        if (sum[MANT_WIDTH]) begin
            if (&big_exp) begin
                add_exp  = '1;
                add_mant = '1;
                add_ovf  = 1'b1;
            end else begin
                add_exp  = big_exp + EXP_WIDTH'(1);
                add_mant = sum[MANT_WIDTH:1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_exp       <= '0;
            acc_mant      <= '0;
            ovf_sticky    <= 1'b0;
            cnt           <= '0;
            op_exp        <= '0;
            op_mant       <= '0;
            op_last       <= 1'b0;
            big_exp       <= '0;
            big_mant      <= '0;
            small_shifted <= '0;
            out_valid     <= 1'b0;
            out_exp       <= '0;
            out_mant      <= '0;
            out_ovf       <= 1'b0;
            out_count     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (accept) begin
                        op_exp  <= in_exp;
                        op_mant <= in_mant;
                        op_last <= in_last;
                        cnt     <= cnt + COUNT_WIDTH'(1);
                    end
                end
                S_ALIGN: begin
                    big_exp       <= al_big_exp;
                    big_mant      <= al_big_mant;
                    small_shifted <= al_small;
                end
                S_ADD: begin
                    acc_exp    <= add_exp;
                    acc_mant   <= add_mant;
                    ovf_sticky <= add_ovf;
                    // Output registers load here so they are valid throughout DONE.
                    if (op_last) begin
                        out_valid <= 1'b1;
                        out_exp   <= add_exp;
                        out_mant  <= add_mant;
                        out_ovf   <= add_ovf;
                        out_count <= cnt;
                    end
                end
                S_DONE: begin
                    acc_exp    <= '0;
                    acc_mant   <= '0;
                    ovf_sticky <= 1'b0;
                    cnt        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flp_accumulator.sv
// tb/tb_flp_accumulator.sv - directed self-checking bench for flp_accumulator
module tb_flp_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [8:0] in_exp;
    logic [7:0] in_mant;
    logic       out_valid, out_ovf;
    logic [8:0] out_exp;
    logic [7:0] out_mant, out_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] tp_exp [3];
    logic       tp_last [3];

    always #5 clk = ~clk;

    flp_accumulator #(.EXP_WIDTH(9), .MANT_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [8:0] e, input logic [7:0] m, input logic l);
        in_exp   = e;
        in_mant  = m;
        in_last  = l;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !in_ready; k++)
            @(negedge clk);
        check("push_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [8:0] e, input logic [7:0] m,
                               input logic ovf, input logic [7:0] count);
        int k;
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 3);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_exp"}, out_exp, e);
        check({tag, "_mant"}, out_mant, m);
        check({tag, "_ovf"}, out_ovf, ovf);
        check({tag, "_count"}, out_count, count);
        @(negedge clk);
        check({tag, "_pulse"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
        check({tag, "_hold_exp"}, out_exp, e);
    endtask

    initial begin
        logic seen;
        int   idx;

        tp_exp  = '{9'd0, 9'd0, 9'd1};
        tp_last = '{1'b0, 1'b0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_exp", out_exp, 0);
        check("rst_mant", out_mant, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_count", out_count, 0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", in_ready, 1);

        push(9'd3, 8'h80, 1'b0);
        push(9'd3, 8'h80, 1'b1);
        wait_result("equal", 9'd4, 8'h80, 1'b0, 8'd2);

        push(9'd5, 8'h80, 1'b0);
        push(9'd3, 8'h80, 1'b1);
        wait_result("align", 9'd5, 8'hA0, 1'b0, 8'd2);

        push(9'd20, 8'h80, 1'b0);
        push(9'd10, 8'h80, 1'b1);
        wait_result("far", 9'd20, 8'h80, 1'b0, 8'd2);

        push(9'd511, 8'h80, 1'b0);
        push(9'd511, 8'h80, 1'b1);
        wait_result("sat", 9'd511, 8'hFF, 1'b1, 8'd2);

        push(9'd2, 8'h80, 1'b1);
        wait_result("post_sat", 9'd2, 8'h80, 1'b0, 8'd1);

        push(9'd0, 8'h00, 1'b0);
        push(9'd4, 8'hC0, 1'b1);
        wait_result("zero", 9'd4, 8'hC0, 1'b0, 8'd2);

        // in_valid held high across three terms; sampling starts on a negedge
        idx      = 0;
        in_exp   = tp_exp[0];
        in_mant  = 8'h80;
        in_last  = tp_last[0];
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("tp_ready_c%0d", c), in_ready, (c == 0 || c == 3 || c == 6));
            check($sformatf("tp_valid_c%0d", c), out_valid, (c == 9));
            if (c == 9) begin
                check("tp_exp", out_exp, 9'd2);
                check("tp_mant", out_mant, 8'h80);
                check("tp_count", out_count, 8'd3);
            end
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < 3) begin
                    in_exp  = tp_exp[idx];
                    in_last = tp_last[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("tp_hold_exp", out_exp, 9'd2);

        push(9'd6, 8'h80, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_exp", out_exp, 0);
        check("midrst_mant", out_mant, 0);
        check("midrst_ovf", out_ovf, 0);
        check("midrst_count", out_count, 0);
        check("midrst_ready_back", in_ready, 1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_no_valid", seen, 0);

        push(9'd1, 8'h80, 1'b1);
        wait_result("after_rst", 9'd1, 8'h80, 1'b0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
